// File: rtl/secuenciador_suma.sv
// secuenciador_suma: accumulates TERMS signed operands with symmetric saturation
// and then publishes the sum as a registered result with a one-cycle valid pulse.
//   clk, reset_n   : clock and asynchronous active-low reset
//   start, abort   : begin (sampled in IDLE) / cancel an operation
//   term_valid/term: signed operand handshake, accepted while term_ready is high
//   term_ready     : high while the block is collecting terms (state decode)
//   result         : saturated sum of the last completed operation
//   result_valid   : one-cycle pulse, high during the DONE cycle
//   busy           : operation in progress (ACC or DONE)
//   sat_flag       : last completed operation saturated at least once
module secuenciador_suma #(
    parameter int unsigned N     = 25,
    parameter int unsigned TERMS = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic                term_valid,
    input  logic signed [N-1:0] term,
    output logic                term_ready,
    output logic signed [N-1:0] result,
    output logic                result_valid,
    output logic                busy,
    output logic                sat_flag
);

    localparam int unsigned CNT_W = $clog2(TERMS + 1);
    // Symmetric limits: the most negative code is never produced by saturation.
    localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_int_q, sat_int_d;
    logic [N-1:0]     result_q, result_d;
    logic             sat_flag_q, sat_flag_d;
    logic             result_valid_q, result_valid_d;

    logic [N-1:0]     sum_raw;
    logic             ovf_pos;
    logic             ovf_neg;
    logic [N-1:0]     sum_sat;

    // Saturating adder: overflow detected from operand signs vs wrapped-sum sign.
    always_comb begin
        sum_raw = acc_q + term;
        ovf_pos = !acc_q[N-1] && !term[N-1] &&  sum_raw[N-1];
        ovf_neg =  acc_q[N-1] &&  term[N-1] && !sum_raw[N-1];
        if (ovf_pos) begin
            sum_sat = SAT_MAX;
        end else if (ovf_neg) begin
            sum_sat = SAT_MIN;
        end else begin
            sum_sat = sum_raw;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            cnt_q          <= '0;
            sat_int_q      <= 1'b0;
            result_q       <= '0;
            sat_flag_q     <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            sat_int_q      <= sat_int_d;
            result_q       <= result_d;
            sat_flag_q     <= sat_flag_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        sat_int_d      = sat_int_q;
        result_d       = result_q;
        sat_flag_d     = sat_flag_q;
        result_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    acc_d     = '0;
                    cnt_d     = '0;
                    sat_int_d = 1'b0;
                    state_d   = ACC;
                end
            end
            ACC: begin
                if (abort) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (term_valid) begin
                    acc_d     = sum_sat;
                    cnt_d     = cnt_q + CNT_W'(1);
                    sat_int_d = sat_int_q | ovf_pos | ovf_neg;
                    if (cnt_q == CNT_W'(TERMS - 1)) begin
                        result_d       = sum_sat;
                        sat_flag_d     = sat_int_q | ovf_pos | ovf_neg;
                        result_valid_d = 1'b1;
                        state_d        = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign term_ready   = (state_q == ACC);
    assign busy         = (state_q != IDLE);
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign sat_flag     = sat_flag_q;

endmodule
